fpu_div_iter: RTL

- Multi-cycle IEEE-754 single-precision divider: result = rs1 / rs2.
- Sits directly downstream of the FPU top-level operation select. The top issues a start pulse with the operands when the DIV operation is selected, and muxes result/flags onto alu_out when done pulses.
- Produces one quotient bit per cycle (restoring division), followed by round-to-nearest-even.
- Subnormal inputs are treated as zero (DAZ). Subnormal outputs are flushed to zero (FTZ).

---
 rtl/fpu_div_iter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/fpu_div_iter.sv
// rtl/fpu_div_iter.sv - iterative IEEE-754 binary32 divider (restoring, RNE, DAZ/FTZ)
//
// Purpose: result = rs1 / rs2, one quotient bit per cycle, then round-to-nearest-even.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : request, sampled only while idle; operands latched on acceptance
//   rs1, rs2      : dividend, divisor (binary32)
//   busy          : high from the cycle after acceptance through the done cycle
//   done          : one-cycle pulse; result/flags valid and held afterwards
//   result, flags : quotient and {NV,DZ,OF,UF,NX}
module fpu_div_iter #(
  parameter int QBITS = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  flags
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_ROUND, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [25:0]        rem_q, rem_d;
  logic [23:0]        mb_q, mb_d;
  logic [25:0]        quo_q, quo_d;
  logic signed [9:0]  exp_q, exp_d;
  logic               sign_q, sign_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        result_q, result_d;
  logic [4:0]         flags_q, flags_d;

  // operand classification (subnormals fold into zero)
  logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan;
  logic [23:0] ma, mb;
  // iteration and rounding datapath
  logic [26:0]       trial;
  logic              g_bit, r_bit, s_bit, inc;
  logic [24:0]       sum;
  logic signed [9:0] exp_r;
  logic [22:0]       frac_r;

  always_comb begin
    zero_a = (a_q[30:23] == 8'd0);
    zero_b = (b_q[30:23] == 8'd0);
    inf_a  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
    inf_b  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
    nan_a  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
    nan_b  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
    snan   = (nan_a && !a_q[22]) || (nan_b && !b_q[22]);
    ma     = {1'b1, a_q[22:0]};
    mb     = {1'b1, b_q[22:0]};

    // rem < 2*mb always holds, so a non-negative trial fits in 25 bits
    trial  = {1'b0, rem_q} - {3'b000, mb_q};

    g_bit  = quo_q[1];
    r_bit  = quo_q[0];
    s_bit  = |rem_q;
    inc    = g_bit && (r_bit || s_bit || quo_q[2]);
    sum    = {1'b0, 1'b1, quo_q[24:2]} + {24'd0, inc};
    exp_r  = exp_q + {9'd0, sum[24]};
    frac_r = sum[24] ? sum[23:1] : sum[22:0];
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    mb_d     = mb_q;
    quo_d    = quo_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = rs1;
          b_d     = rs2;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        sign_d  = a_q[31] ^ b_q[31];
        state_d = S_DONE;
        if (nan_a || nan_b) begin
          result_d = 32'h7FC00000;
          flags_d  = {snan, 4'b0000};
        end else if ((zero_a && zero_b) || (inf_a && inf_b)) begin
          result_d = 32'h7FC00000;
          flags_d  = 5'b10000;
        end else if (zero_b && !inf_a) begin
          result_d = {a_q[31] ^ b_q[31], 8'hFF, 23'd0};
          flags_d  = 5'b01000;
        end else if (inf_a) begin
          result_d = {a_q[31] ^ b_q[31], 8'hFF, 23'd0};
          flags_d  = 5'b00000;
        end else if (zero_a || inf_b) begin
          result_d = {a_q[31] ^ b_q[31], 31'd0};
          flags_d  = 5'b00000;
        end else begin
          // pre-normalise so the first quotient bit is always the implicit 1
          exp_d = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd127;
          if (ma < mb) begin
            rem_d = {1'b0, ma, 1'b0};
            exp_d = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd126;
          end else begin
            rem_d = {2'b00, ma};
          end
          mb_d    = mb;
          quo_d   = 26'd0;
          cnt_d   = 5'(QBITS - 1);
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (!trial[26]) begin
          rem_d = {trial[24:0], 1'b0};
          quo_d = {quo_q[24:0], 1'b1};
        end else begin
          rem_d = {rem_q[24:0], 1'b0};
          quo_d = {quo_q[24:0], 1'b0};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = S_ROUND;
      end
      S_ROUND: begin
        state_d = S_DONE;
        if (exp_r >= 10'sd255) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          flags_d  = 5'b00101;
        end else if (exp_r <= 10'sd0) begin
          result_d = {sign_q, 31'd0};
          flags_d  = 5'b00011;
        end else begin
          result_d = {sign_q, exp_r[7:0], frac_r};
          flags_d  = {4'b0000, g_bit | r_bit | s_bit};
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      rem_q    <= 26'd0;
      mb_q     <= 24'd0;
      quo_q    <= 26'd0;
      exp_q    <= 10'sd0;
      sign_q   <= 1'b0;
      cnt_q    <= 5'd0;
      result_q <= 32'd0;
      flags_q  <= 5'd0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      mb_q     <= mb_d;
      quo_q    <= quo_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign flags  = flags_q;

endmodule
